// File: rtl/nibble_serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// nibble_serial_add_ctrl
//
// Performs a WIDTH-bit unsigned addition by time-multiplexing one external
// 4-bit ripple-carry adder, one nibble per clock, least-significant nibble
// first. Operands are captured on an accepted start. Each RUN cycle presents
// one nibble pair plus the chained carry to the adder, collects the returned
// sum nibble and carry, and after the last nibble publishes the full result.
//
// Ports:
//   clk        in   rising-edge system clock
//   rst_n      in   asynchronous active-low reset
//   start      in   request a new addition (accepted in IDLE or DONE)
//   op_a/op_b  in   WIDTH-bit operands, captured on accepted start
//   c_in       in   carry-in, captured on accepted start
//   busy       out  high while the addition is in progress (RUN)
//   done       out  one-cycle pulse when sum/carry_out have just updated
//   sum        out  WIDTH-bit result of the last completed addition
//   carry_out  out  carry out of the MSB nibble of the last completed addition
//   add_a      out  operand A nibble to the shared adder
//   add_b      out  operand B nibble to the shared adder
//   add_cin    out  carry-in to the shared adder
//   add_sum    in   sum nibble returned by the shared adder (combinational)
//   add_cout   in   carry returned by the shared adder (combinational)
// -----------------------------------------------------------------------------
module nibble_serial_add_ctrl #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             c_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out,
   output logic [3:0]       add_a,
   output logic [3:0]       add_b,
   output logic             add_cin,
   input  logic [3:0]       add_sum,
   input  logic             add_cout
);

   localparam int NIB = WIDTH / 4;
   localparam int SW  = $clog2(NIB + 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t           state_r;
   logic [WIDTH-1:0] a_r;        // operand A, shifted right one nibble per step
   logic [WIDTH-1:0] b_r;        // operand B, shifted right one nibble per step
   logic [WIDTH-1:0] part_r;     // partial result, filled from the top down
   logic             carry_r;    // chained carry between nibble steps
   logic [SW-1:0]    step_r;     // current nibble index in RUN

   logic [WIDTH-1:0] part_next_s;
   logic             last_step_s;

   // The adder always sees the low nibble of the shifting operand registers and
   // the carry register. After NIB shifts the operand registers are empty and
   // the carry register is cleared, so these read zero outside RUN.
   assign add_a   = a_r[3:0];
   assign add_b   = b_r[3:0];
   assign add_cin = carry_r;

   // Next partial result: shift down one nibble and insert the returned sum
   // nibble at the top, so after NIB steps nibble k sits at bits [4k+3:4k].
   always_comb begin
      part_next_s = (part_r >> 3'd4) | (WIDTH'(add_sum) << (WIDTH - 4));
      last_step_s = (step_r == SW'(NIB - 1));
   end

   // Sequencing FSM with registered status and result outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= ST_IDLE;
         a_r       <= '0;
         b_r       <= '0;
         part_r    <= '0;
         carry_r   <= 1'b0;
         step_r    <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         sum       <= '0;
         carry_out <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE, ST_DONE: begin
               done <= 1'b0;
               if (start) begin
                  a_r     <= op_a;
                  b_r     <= op_b;
                  carry_r <= c_in;
                  part_r  <= '0;
                  step_r  <= '0;
                  busy    <= 1'b1;
                  state_r <= ST_RUN;
               end else begin
                  busy    <= 1'b0;
                  state_r <= ST_IDLE;
               end
            end
            ST_RUN: begin
               a_r    <= a_r >> 3'd4;
               b_r    <= b_r >> 3'd4;
               part_r <= part_next_s;
               step_r <= step_r + SW'(1);
               if (last_step_s) begin
                  // Carry register is cleared so add_cin idles at zero.
                  carry_r   <= 1'b0;
                  sum       <= part_next_s;
                  carry_out <= add_cout;
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  state_r   <= ST_DONE;
               end else begin
                  carry_r <= add_cout;
                  busy    <= 1'b1;
                  done    <= 1'b0;
                  state_r <= ST_RUN;
               end
            end
            default: begin
               state_r <= ST_IDLE;
               a_r     <= '0;
               b_r     <= '0;
               carry_r <= 1'b0;
               busy    <= 1'b0;
               done    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// tb_nibble_serial_add_ctrl
//
// Self-checking bench for nibble_serial_add_ctrl (WIDTH=16). Provides the
// external 4-bit adder, drives inputs on the falling edge, samples outputs on
// the falling edge, and compares against whole-word arithmetic expectations.
// -----------------------------------------------------------------------------
module tb_nibble_serial_add_ctrl;

   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [W-1:0] op_a;
   logic [W-1:0] op_b;
   logic         c_in;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         carry_out;
   logic [3:0]   add_a;
   logic [3:0]   add_b;
   logic         add_cin;
   logic [3:0]   add_sum;
   logic         add_cout;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // External shared 4-bit adder.
   assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {4'd0, add_cin};

   nibble_serial_add_ctrl #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b),
      .c_in(c_in), .busy(busy), .done(done), .sum(sum), .carry_out(carry_out),
      .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
      .add_sum(add_sum), .add_cout(add_cout)
   );

   // Pulse start for one cycle; returns at the falling edge of cycle 1 after acceptance.
   task automatic do_start(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
      @(negedge clk);
      start = 1'b1; op_a = a; op_b = b; c_in = c;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Count cycles (starting at 1) until done is seen, bounded.
   task automatic wait_done(output int cyc);
      cyc = 1;
      while (done !== 1'b1 && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; op_a = '0; op_b = '0; c_in = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({busy, done, sum, carry_out, add_a, add_b, add_cin} !== '0) begin
         errors++;
         $display("FAIL reset_state got busy=%b done=%b sum=%h cout=%b a=%h b=%h cin=%b want all zero",
                  busy, done, sum, carry_out, add_a, add_b, add_cin);
      end
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL idle_after_reset got busy=%b done=%b want 0 0", busy, done);
      end
   endtask

   task automatic test_directed();
      logic [W-1:0] ta [4] = '{16'h1234, 16'hFFFF, 16'hFFFF, 16'h8000};
      logic [W-1:0] tb_ [4] = '{16'h4321, 16'h0001, 16'h0000, 16'h8000};
      logic         tc [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
      for (int v = 0; v < 4; v++) begin
         int unsigned full;
         full = ta[v] + tb_[v] + tc[v];
         do_start(ta[v], tb_[v], tc[v]);
         for (int k = 0; k < 4; k++) begin
            int unsigned mask, exp_a, exp_b, exp_c;
            mask  = (32'd1 << (4 * k)) - 32'd1;
            exp_a = (ta[v] >> (4 * k)) & 32'hF;
            exp_b = (tb_[v] >> (4 * k)) & 32'hF;
            exp_c = (((ta[v] & mask) + (tb_[v] & mask) + tc[v]) >> (4 * k)) & 32'd1;
            checks++;
            if (busy !== 1'b1 || done !== 1'b0 || add_a !== exp_a[3:0] ||
                add_b !== exp_b[3:0] || add_cin !== exp_c[0]) begin
               errors++;
               $display("FAIL nibble_step v%0d k%0d got busy=%b done=%b a=%h b=%h cin=%b want 1 0 %h %h %b",
                        v, k, busy, done, add_a, add_b, add_cin, exp_a[3:0], exp_b[3:0], exp_c[0]);
            end
            @(negedge clk);
         end
         checks++;
         if (done !== 1'b1 || busy !== 1'b0 || sum !== full[15:0] || carry_out !== full[16] ||
             add_a !== 4'd0 || add_b !== 4'd0 || add_cin !== 1'b0) begin
            errors++;
            $display("FAIL directed_result v%0d got done=%b busy=%b sum=%h cout=%b a=%h b=%h cin=%b want done=1 busy=0 sum=%h cout=%b adder inputs 0",
                     v, done, busy, sum, carry_out, add_a, add_b, add_cin, full[15:0], full[16]);
         end
         @(negedge clk);
         checks++;
         if (done !== 1'b0 || sum !== full[15:0]) begin
            errors++;
            $display("FAIL done_single_pulse v%0d got done=%b sum=%h want 0 %h", v, done, sum, full[15:0]);
         end
      end
   endtask

   task automatic test_ignore_start();
      int busy_cnt = 0;
      int done_cnt = 0;
      do_start(16'h0001, 16'h0001, 1'b0);
      for (int cyc = 1; cyc <= 8; cyc++) begin
         if (busy === 1'b1) busy_cnt++;
         if (done === 1'b1) done_cnt++;
         if (cyc == 2) begin
            start = 1'b1; op_a = 16'hAAAA; op_b = 16'h0001; c_in = 1'b0;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
      end
      checks++;
      if (busy_cnt != 4 || done_cnt != 1 || sum !== 16'h0002 || carry_out !== 1'b0) begin
         errors++;
         $display("FAIL ignore_start got busy_cycles=%0d dones=%0d sum=%h cout=%b want 4 1 0002 0",
                  busy_cnt, done_cnt, sum, carry_out);
      end
   endtask

   task automatic test_back_to_back();
      int cyc;
      do_start(16'h0001, 16'h0001, 1'b0);
      wait_done(cyc);
      checks++;
      if (cyc != 5 || sum !== 16'h0002) begin
         errors++;
         $display("FAIL b2b_first got cycle=%0d sum=%h want 5 0002", cyc, sum);
      end
      start = 1'b1; op_a = 16'h0F0F; op_b = 16'h00F1; c_in = 1'b0;
      @(negedge clk);
      start = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         checks++;
         if (busy !== 1'b1 || done !== 1'b0 || sum !== 16'h0002) begin
            errors++;
            $display("FAIL b2b_run cycle%0d got busy=%b done=%b sum=%h want 1 0 0002", k, busy, done, sum);
         end
         @(negedge clk);
      end
      checks++;
      if (done !== 1'b1 || sum !== 16'h1000 || carry_out !== 1'b0) begin
         errors++;
         $display("FAIL b2b_second got done=%b sum=%h cout=%b want 1 1000 0", done, sum, carry_out);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_run();
      int cyc;
      do_start(16'h1234, 16'h1111, 1'b1);
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if ({busy, done, sum, carry_out, add_a, add_b, add_cin} !== '0) begin
         errors++;
         $display("FAIL reset_mid_run got busy=%b done=%b sum=%h cout=%b a=%h b=%h cin=%b want all zero",
                  busy, done, sum, carry_out, add_a, add_b, add_cin);
      end
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (k == 1) rst_n = 1'b1;
         checks++;
         if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL no_done_after_abort k%0d got done=%b busy=%b want 0 0", k, done, busy);
         end
      end
      do_start(16'h0003, 16'h0004, 1'b0);
      wait_done(cyc);
      checks++;
      if (cyc != 5 || sum !== 16'h0007 || carry_out !== 1'b0) begin
         errors++;
         $display("FAIL after_reset_add got cycle=%0d sum=%h cout=%b want 5 0007 0", cyc, sum, carry_out);
      end
      @(negedge clk);
   endtask

   task automatic test_random();
      for (int n = 0; n < 40; n++) begin
         logic [W-1:0] a, b;
         logic         c;
         int unsigned  full;
         int           cyc;
         a = W'($urandom); b = W'($urandom); c = 1'($urandom);
         if (n == 0) begin a = 16'hFFFF; b = 16'hFFFF; c = 1'b1; end
         full = a + b + c;
         do_start(a, b, c);
         // Inputs wander during RUN; the in-flight result must not move.
         op_a = W'($urandom); op_b = W'($urandom); c_in = 1'($urandom);
         wait_done(cyc);
         checks++;
         if (cyc != 5 || sum !== full[15:0] || carry_out !== full[16]) begin
            errors++;
            $display("FAIL random n%0d a=%h b=%h c=%b got cycle=%0d sum=%h cout=%b want 5 %h %b",
                     n, a, b, c, cyc, sum, carry_out, full[15:0], full[16]);
         end
         repeat ($urandom_range(1, 2)) @(negedge clk);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_ignore_start();
      test_back_to_back();
      test_reset_mid_run();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/nibble_serial_add_ctrl.md
Name: nibble_serial_add_ctrl

Overview:
Sequencing controller that performs a WIDTH-bit addition by time-multiplexing one external 4-bit ripple-carry adder, one nibble per clock, LSB nibble first. It captures the operands on a start handshake and drives the adder's a/b/c inputs each cycle. It chains the adder's carry through an internal carry register and assembles the full-width result. It sits between a requester (start/busy/done) and a single shared 4-bit adder instance in the arithmetic datapath.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4
NIB, WIDTH/4, number of nibble steps (derived; not overridable)

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request a new addition; sampled only when accepted (see Behaviour)
op_a  input  WIDTH  operand A, captured on accepted start
op_b  input  WIDTH  operand B, captured on accepted start
c_in  input  1  carry-in, captured on accepted start
busy  output  1  high while an addition is in progress (state RUN)
done  output  1  one-cycle pulse: sum/carry_out just updated
sum  output  WIDTH  result of last completed addition
carry_out  output  1  carry out of MSB nibble of last completed addition
add_a  output  4  nibble of A to the shared adder
add_b  output  4  nibble of B to the shared adder
add_cin  output  1  carry-in to the shared adder
add_sum  input  4  sum nibble returned by the adder (combinational)
add_cout  input  1  carry returned by the adder (combinational)

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, busy=0, done=0, sum=0, carry_out=0, step counter=0, carry register=0, operand/partial registers=0, add_a=0, add_b=0, add_cin=0.
- States: IDLE, RUN, DONE.
- start is accepted in IDLE or DONE. On accept: latch op_a, op_b, c_in; carry register <= c_in; step <= 0; next state RUN. start in RUN is ignored; no queuing.
- RUN, step k (0..NIB-1):
  - add_a = A[4k+3:4k], add_b = B[4k+3:4k], add_cin = carry register. All are driven from registers: no combinational path from start/op_* to add_*.
  - At the clock edge: partial result nibble k <= add_sum, carry register <= add_cout, step <= k+1.
  - After step NIB-1: sum <= full partial result (with nibble NIB-1 = add_sum), carry_out <= add_cout, next state DONE.
- DONE: done=1 for exactly this one cycle, busy=0. Next state IDLE, or RUN if start is asserted (back-to-back).
- add_a/add_b/add_cin outside RUN: held at 0.
- Latency: start accepted at edge E0. busy is high for NIB cycles after E0. done is high in cycle NIB+1 after E0; for WIDTH=16 that is the 5th cycle after E0. Throughput is one addition per NIB+1 cycles.
- sum/carry_out change only on the RUN->DONE transition and hold otherwise, including during a subsequent RUN.
- Arithmetic: {carry_out, sum} = op_a + op_b + c_in, modulo 2^(WIDTH+1), unsigned.
- Reset mid-RUN aborts immediately: no done pulse, sum/carry_out=0. The first start after release is handled normally.
- op_a/op_b/c_in changing during RUN has no effect on the in-flight result.

Test Plan:
- WIDTH=16, start with A=0x1234, B=0x4321, c_in=0 -> add_a sequence 4,3,2,1; done in 5th cycle; sum=0x5555, carry_out=0.
- A=0xFFFF, B=0x0001, c_in=0 -> add_cin sequence 0,1,1,1; sum=0x0000, carry_out=1.
- A=0xFFFF, B=0x0000, c_in=1 -> sum=0x0000, carry_out=1. A=0x8000, B=0x8000, c_in=0 -> sum=0x0000, carry_out=1.
- Pulse start with A=0x0001, B=0x0001, then assert start with A=0xAAAA in 2nd RUN cycle -> ignored; single done; sum=0x0002; busy stays high 4 cycles.
- Assert start during the DONE cycle with A=0x0F0F, B=0x00F1 -> busy rises next cycle with no IDLE gap; prior sum (e.g. 0x0002) held until new done; new sum=0x1000, carry_out=0.
- Drive rst_n low in 3rd RUN cycle -> busy=0, sum=0, carry_out=0, add_*=0 immediately; no done pulse; a later A=0x0003, B=0x0004 start yields sum=0x0007.
